// File: rtl/tdm_pkg.sv
// Shared types and helpers for the tdm_demux4 TDM frame demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int CH_DEFAULT = 4;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage : tdm_pkg

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of tdm_demux4; par_err exists only with TDM_PARITY_EN.
interface tdm_demux4_if #(
  parameter int CH = tdm_pkg::CH_DEFAULT,
  parameter int SW = tdm_pkg::clog2(CH + 1)
);

  logic          d_in;
  logic          d_vld;
  logic          sync;
  logic [SW-1:0] s_out;
  logic [CH-1:0] y;
  logic          y_vld;
  logic          locked;
  logic          sync_err;
`ifdef TDM_PARITY_EN
  logic          par_err;

  modport master (
    output d_in, d_vld, sync,
    input  s_out, y, y_vld, locked, sync_err, par_err
  );

  modport slave (
    input  d_in, d_vld, sync,
    output s_out, y, y_vld, locked, sync_err, par_err
  );
`else
  modport master (
    output d_in, d_vld, sync,
    input  s_out, y, y_vld, locked, sync_err
  );

  modport slave (
    input  d_in, d_vld, sync,
    output s_out, y, y_vld, locked, sync_err
  );
`endif

endinterface : tdm_demux4_if

// File: rtl/tdm_slot_ctr.sv
// Slot counter: advances on enable, wraps after LAST, and a sync load forces slot 1.
module tdm_slot_ctr #(
  parameter int LAST = 3,
  parameter int SW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          load1_i,
  output logic [SW-1:0] slot_o
);

  logic [SW-1:0] slot_q, slot_d;

  always_comb begin
    // NOTE: default first so every path assigns slot_d and no latch is inferred.
    slot_d = slot_q;
    if (load1_i) begin
      slot_d = SW'(1);
    end else if (en_i) begin
      slot_d = (slot_q == SW'(LAST)) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: owns the upstream mux select, aligns on sync, emits parallel words.
// Optional TDM_PARITY_EN appends an even-parity slot per frame and adds par_err.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int CH = CH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  localparam int SW = clog2(CH + 1);
`ifdef TDM_PARITY_EN
  localparam int LAST = CH;
`else
  localparam int LAST = CH - 1;
`endif
  // Bits held before the completing slot: all data bits when parity closes the frame.
  localparam int SHW = LAST;

  state_e         state_q;
  logic [SW-1:0]  slot_q;
  logic [SHW-1:0] shadow_q;
  logic [CH-1:0]  y_q;
  logic           y_vld_q;
  logic           locked_q;
  logic           sync_err_q;
`ifdef TDM_PARITY_EN
  logic           par_err_q;
`endif

  logic start;
  assign start = bus.d_vld & bus.sync;

  // Any valid sync re-aligns to slot 1; in-frame slots advance only when locked.
  tdm_slot_ctr #(
    .LAST (LAST),
    .SW   (SW)
  ) u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (bus.d_vld & (state_q == LOCKED)),
    .load1_i (start),
    .slot_o  (slot_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      shadow_q   <= '0;
      y_q        <= '0;
      y_vld_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      y_vld_q    <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
      case (state_q)
        HUNT: begin
          if (start) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            shadow_q <= SHW'(bus.d_in);
          end
        end
        LOCKED: begin
          if (start && (slot_q != '0)) begin
            // Misaligned marker: drop the partial frame and restart on this bit.
            sync_err_q <= 1'b1;
            shadow_q   <= SHW'(bus.d_in);
          end else if (bus.d_vld) begin
            if (slot_q == SW'(LAST)) begin
              y_vld_q   <= 1'b1;
`ifdef TDM_PARITY_EN
              y_q       <= shadow_q;
              par_err_q <= ^{shadow_q, bus.d_in};
`else
              y_q       <= {bus.d_in, shadow_q};
`endif
            end else begin
              for (int k = 0; k < SHW; k++) begin
                if (slot_q == SW'(k)) shadow_q[k] <= bus.d_in;
              end
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign bus.s_out    = slot_q;
  assign bus.y        = y_q;
  assign bus.y_vld    = y_vld_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;
`ifdef TDM_PARITY_EN
  assign bus.par_err  = par_err_q;
`endif

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (CH=4): vector table plus hand-written corner sequences.
module tb_tdm_demux4;
  import tdm_pkg::*;

  localparam int CH = 4;
  localparam int SW = clog2(CH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux4_if #(.CH(CH)) bus ();

  tdm_demux4 #(.CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Packed output view: {s_out[2:0], y[3:0], y_vld, locked, sync_err}
  typedef struct {
    logic       v;
    logic       s;
    logic       d;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.s_out, bus.y, bus.y_vld, bus.locked, bus.sync_err};
  endfunction

  function automatic vec_t mk(input logic v, s, d, input logic [2:0] slot,
                              input logic [3:0] y, input logic vld, lk, serr);
    vec_t r;
    r.v = v; r.s = s; r.d = d;
    r.exp = {slot, y, vld, lk, serr};
    return r;
  endfunction

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic step(input logic v, s, d);
    bus.d_vld = v;
    bus.sync  = s;
    bus.d_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.d_vld = 1'b0;
    bus.sync  = 1'b0;
    bus.d_in  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    // Data without sync never locks.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, i[0]);
      check($sformatf("hunt_no_sync_%0d", i), 32'(outs()), 32'd0);
    end

`ifndef TDM_PARITY_EN
    // Frame 1,0,1,1 with sync -> 1101
    tbl.push_back(mk(1, 1, 1, 3'd1, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 4'b1101, 1, 1, 0));
    // Back-to-back 0110 (sync) then 1001 (flywheel)
    tbl.push_back(mk(1, 1, 0, 3'd1, 4'b1101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd2, 4'b1101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 4'b1101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd0, 4'b0110, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd1, 4'b0110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b0110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd3, 4'b0110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 4'b1001, 1, 1, 0));
    // Sync at slot 2 with d_in=1, then 0,1,0 -> 0101
    tbl.push_back(mk(1, 0, 0, 3'd1, 4'b1001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b1001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 3'd1, 4'b1001, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b1001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 4'b1001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd0, 4'b0101, 1, 1, 0));
    // Five-cycle gap after slot 1 (one gap cycle carries a stray sync) -> 1110
    tbl.push_back(mk(1, 1, 0, 3'd1, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3'd2, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 4'b1110, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 4'b1110, 0, 1, 0));
    // Sync on the last slot: no completion, restart -> 1,0,0,1 = 1001
    tbl.push_back(mk(1, 0, 1, 3'd1, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 3'd1, 4'b1110, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'd2, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd3, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 4'b1001, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec_%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
`endif

    // Asynchronous reset mid-frame discards the partial frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("post_reset_hunt", 32'(outs()), 32'd0);

`ifndef TDM_PARITY_EN
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("post_reset_frame", 32'(outs()), 32'({3'd0, 4'b0100, 1'b1, 1'b1, 1'b0}));
`else
    // Data 1011 (slots 0..3 = 1,1,0,1), parity 0 -> odd ones -> par_err
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("par_slot4", 32'({bus.s_out, bus.y_vld}), 32'({3'd4, 1'b0}));
    step(1'b1, 1'b0, 1'b0);
    check("par_bad", 32'({bus.s_out, bus.y, bus.y_vld, bus.par_err}),
          32'({3'd0, 4'b1011, 1'b1, 1'b1}));
    step(1'b0, 1'b0, 1'b0);
    check("par_pulse_end", 32'({bus.y_vld, bus.par_err}), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("par_good", 32'({bus.s_out, bus.y, bus.y_vld, bus.par_err}),
          32'({3'd0, 4'b1011, 1'b1, 1'b0}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux4
